// File: rtl/md_unit_pkg.sv
// Shared constants and types for the M-extension execute unit.
package md_unit_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDiv  = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } md_state_e;

  function automatic logic is_signed_div(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage

// File: rtl/md_div_step.sv
// One combinational radix-2 restoring divide iteration on a rem:quo pair.
module md_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  // One extra bit: the shifted partial remainder can reach 2*divisor-1.
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, divisor_i};
    fits    = shifted >= {1'b0, divisor_i};
    rem_o   = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_o   = {quo_i[XLEN-2:0], fits};
  end

endmodule

// File: rtl/md_unit.sv
// RV M-extension execute unit: single-cycle multiply, iterative restoring divide.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state_q, state_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sel_rem_q, sel_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept;
  logic            is_div, is_rem, div_signed, a_neg, b_neg, div_zero, div_ovf;
  logic            a_mul_signed, b_mul_signed;
  logic [XLEN-1:0] a_abs, b_abs, fast_res, mul_res;
  logic [2*XLEN-1:0] mul_a, mul_b, product;
  logic [XLEN-1:0] step_rem, step_quo;

  md_div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dvsr_q),
    .rem_o    (step_rem),
    .quo_o    (step_quo)
  );

  // Operand decode for the accept edge; everything after accept uses latched state.
  always_comb begin
    accept       = start_i && (state_q == StIdle) && !flush_i;
    is_div       = funct3_i[2];
    is_rem       = is_rem_op(funct3_i);
    div_signed   = is_signed_div(funct3_i);
    a_neg        = div_signed && op_a_i[XLEN-1];
    b_neg        = div_signed && op_b_i[XLEN-1];
    a_abs        = a_neg ? (~op_a_i + 1'b1) : op_a_i;
    b_abs        = b_neg ? (~op_b_i + 1'b1) : op_b_i;
    div_zero     = (op_b_i == '0);
    div_ovf      = div_signed && (op_a_i == MinNeg) && (op_b_i == '1);

    if (div_zero) begin
      fast_res = is_rem ? op_a_i : '1;
    end else begin
      fast_res = is_rem ? '0 : op_a_i;
    end

    a_mul_signed = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU);
    b_mul_signed = (funct3_i == F3_MULH);
    mul_a        = {{XLEN{a_mul_signed && op_a_i[XLEN-1]}}, op_a_i};
    mul_b        = {{XLEN{b_mul_signed && op_b_i[XLEN-1]}}, op_b_i};
    product      = mul_a * mul_b;
    mul_res      = (funct3_i == F3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      sel_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      sel_rem_q <= sel_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (is_div && !div_zero && !div_ovf) ? StDiv : StDone;
        end
      end
      // The last of the XLEN steps is folded into FIX, so DIV exits one count early.
      StDiv:  state_d = flush_i ? StIdle : ((cnt_q == CntW'(1)) ? StFix : StDiv);
      StFix:  state_d = flush_i ? StIdle : StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    sel_rem_d = sel_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sel_rem_d = is_rem;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (!is_div) begin
            result_d = mul_res;
          end else if (div_zero || div_ovf) begin
            result_d = fast_res;
          end else begin
            rem_d  = '0;
            quo_d  = a_abs;
            dvsr_d = b_abs;
            cnt_d  = CntW'(XLEN - 1);
          end
        end
      end
      StDiv: begin
        if (!flush_i) begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        if (!flush_i) begin
          if (sel_rem_q) begin
            result_d = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
          end else begin
            result_d = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ready_o  = (state_q == StIdle);
    busy_o   = (state_q != StIdle);
    done_o   = (state_q == StDone);
    result_o = result_q;
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed table, random ops vs arithmetic model, corner sequences.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        flush_i;
  logic        ready_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_total = 0;
  int n_pass  = 0;

  md_unit #(
    .XLEN(32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .funct3_i(funct3_i),
    .op_a_i  (op_a_i),
    .op_b_i  (op_b_i),
    .flush_i (flush_i),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .result_o(result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: RISC-V M semantics via 64-bit integer arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3 < 3'd4 || b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op from IDLE; returns result, latency (accept edge to done), busy/ready sanity.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit hold, output logic [31:0] res, output int lat,
                       output bit busy_ok);
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = f3;
    op_a_i   = a;
    op_b_i   = b;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start_i = 1'b0;
    op_a_i   = $urandom;
    op_b_i   = $urandom;
    funct3_i = 3'($urandom);
    lat      = 1;
    busy_ok  = 1'b1;
    while (!done_o && lat < 100) begin
      if (!busy_o || ready_o) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!busy_o || ready_o) busy_ok = 1'b0;
    res     = result_o;
    start_i = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t        vecs[$];
    logic [31:0] res;
    int          lat;
    bit          bok;
    int          dones;

    rst = 1'b1; start_i = 1'b0; funct3_i = '0; op_a_i = '0; op_b_i = '0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ready", 32'(ready_o), 32'd1);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    check("reset result", result_o, 32'd0);
    rst = 1'b0;

    vecs = '{
      '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1},
      '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1},
      '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1},
      '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1},
      '{3'd4, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, 33},
      '{3'd6, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 33},
      '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1},
      '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1},
      '{3'd7, 32'd5,         32'd0,         32'd5,         1},
      '{3'd6, 32'd5,         32'd0,         32'd5,         1},
      '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
      '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1},
      '{3'd5, 32'd100,       32'd7,         32'd14,        33}
    };
    foreach (vecs[i]) begin
      do_op(vecs[i].f3, vecs[i].a, vecs[i].b, 1'b0, res, lat, bok);
      check($sformatf("vec%0d result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d busy/ready", i), 32'(bok), 32'd1);
    end

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      do_op(f3, a, b, 1'b0, res, lat, bok);
      check($sformatf("rand%0d f3=%0d a=%08h b=%08h", i, f3, a, b), res, ref_md(f3, a, b));
      check($sformatf("rand%0d latency", i), 32'(lat), 32'(ref_lat(f3, a, b)));
    end

    // start held through the whole divide, inputs scrambled after accept
    do_op(3'd5, 32'd1000, 32'd9, 1'b1, res, lat, bok);
    check("held start result", res, 32'd111);
    check("held start latency", 32'(lat), 32'd33);
    @(negedge clk);
    check("idle after held start", 32'(ready_o), 32'd1);

    // flush 10 cycles into a divide
    do_op(3'd0, 32'd7, 32'd3, 1'b0, res, lat, bok);
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd5; op_a_i = 32'd100; op_b_i = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush ready", 32'(ready_o), 32'd1);
    check("flush busy", 32'(busy_o), 32'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_o) dones++;
      @(negedge clk);
    end
    check("flush no done", 32'(dones), 32'd0);
    check("flush result kept", result_o, 32'd21);

    // flush together with start in IDLE blocks the accept
    start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd0; op_a_i = 32'd2; op_b_i = 32'd2;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    check("flush beats start", 32'(ready_o), 32'd1);
    @(negedge clk);
    check("flush beats start done", 32'(done_o), 32'd0);

    // reset mid-divide
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd4; op_a_i = 32'hFFFF_FFEC; op_b_i = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid reset ready", 32'(ready_o), 32'd1);
    check("mid reset busy", 32'(busy_o), 32'd0);
    check("mid reset done", 32'(done_o), 32'd0);
    check("mid reset result", result_o, 32'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_o) dones++;
      @(negedge clk);
    end
    check("mid reset no done", 32'(dones), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised RV M-extension execute unit; sits beside the ALU in EX and handles all funct7=0000001 R-type ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Upstream decode raises start_i and holds the pipeline on busy_o until done_o.
- Multiply is single-cycle registered; divide is an iterative radix-2 restoring FSM.
- Divide-by-zero and signed overflow follow the RISC-V spec and take a fast path.

Parameters:
- XLEN, 32, operand/result width (any even value >= 8).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request; accepted only on an edge where ready_o=1.
- funct3_i  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a_i  in  XLEN  rs1 value, sampled at accept.
- op_b_i  in  XLEN  rs2 value, sampled at accept.
- flush_i  in  1  abort any in-flight op (branch mispredict/trap).
- ready_o  out  1  high in IDLE only.
- busy_o  out  1  high from accept until (and including) the done_o cycle.
- done_o  out  1  one-cycle pulse, result_o valid.
- result_o  out  XLEN  holds last result until the next done_o.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, ready_o=1, busy_o=0, done_o=0, result_o=0, all internal regs cleared. rst overrides start_i and flush_i.
- States: IDLE, DIV, FIX, DONE.
- Accept: start_i=1 & ready_o=1 at edge E0. Latch funct3, operands and sign flags.
  - MUL*: compute 2*XLEN-bit product (operands sign/zero-extended per op), register selected half, go to DONE. done_o high in cycle after E0 (L=1).
  - MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits. MULHSU: a signed, b unsigned.
  - DIV/REM family, b==0: quotient = all ones; remainder = a (unsigned and signed). Go to DONE, L=1.
  - DIV/REM, signed, a=1<<(XLEN-1), b=all ones: quotient = a, remainder = 0. Go to DONE, L=1.
  - Otherwise: take |a|, |b| for signed ops; enter DIV with count=XLEN-1.
- DIV: one restoring step per cycle (shift rem:quo left 1, trial-subtract divisor, set quo LSB). Count decrements; at count=0 go to FIX.
- FIX: negate quotient if sign(a)^sign(b) (signed DIV); negate remainder if sign(a) (signed REM). Register the selected result, go to DONE. Normal divide L = XLEN+1 (33 for XLEN=32).
- DONE: done_o=1 for exactly one cycle, busy_o=1, ready_o=0; next state IDLE. Back-to-back issue: earliest next accept is the edge after DONE.
- start_i while busy: ignored, no queueing.
- flush_i=1 at any edge outside IDLE: state->IDLE, no done_o, result_o unchanged. This includes the DONE cycle: its pulse still appears that cycle and the edge is a no-op.
- flush_i with start_i in IDLE: flush wins, no accept.
- funct3 and operands are used only from latched copies; input changes after accept have no effect.

Decomposition:
- Add to defines.v as shared constants: F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU, F3_DIV, F3_DIVU, F3_REM, F3_REMU; F7_MULDIV = 7'b0000001; MD state encodings.
- One sub-module, md_div_step: combinational single restoring iteration, parametrised by XLEN. Inputs: rem, quo, divisor. Outputs: next rem, next quo.
- Multiplier stays inline.

Test Plan (XLEN=32):
- MUL a=7, b=0xFFFFFFFD, start 1 cycle -> done_o 1 cycle later, result_o=0xFFFFFFEB.
- High-half multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide a=0xFFFFFFEC (-20), b=3:
  - DIV -> 0xFFFFFFFA, done_o exactly 33 cycles after accept.
  - REM -> 0xFFFFFFFE.
  - busy_o high for all 33 cycles; ready_o low throughout.
- Divide by zero, a=5, b=0:
  - DIVU -> 0xFFFFFFFF; DIV -> 0xFFFFFFFF; REMU -> 5; REM -> 5.
  - All with L=1.
- Overflow a=0x80000000, b=0xFFFFFFFF: DIV -> 0x80000000, REM -> 0, L=1.
- Abort and ignore cases:
  - DIVU 100/7 with flush_i pulsed 10 cycles after accept -> no done_o, ready_o=1 next cycle, result_o retains prior value.
  - start_i held during busy is ignored.
  - rst asserted mid-divide -> all outputs at reset values next cycle.
